// File: rtl/dmem_bridge.sv
// dmem_bridge: converts the MEM stage's single-cycle data-memory request into a
// req/ack transaction on a word-addressed RAM port, stalling the core until the
// transaction completes or times out.
//
// Optional feature macro: DMEM_LASTHIT_EN
//   When defined, adds a one-entry last-access register that serves repeat reads
//   of the most recently completed word with zero stall.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   dmemaddr/dmemwdata    core byte address (bit 0 ignored) and store data
//   dmemwrite/dmemread    core store / load request
//   dmemrdata             registered load data
//   dmemstall             combinational freeze to the core
//   dmemerr               sticky error (timeout or read+write together)
//   ramaddr/ramwdata      registered RAM word address and store data
//   ramreq/ramwe          registered RAM request and write enable
//   ramrdata/ramack       RAM read data and completion strobe
`timescale 1ns/1ps
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  output logic        dmemstall,
  output logic        dmemerr,
  output logic [14:0] ramaddr,
  output logic [15:0] ramwdata,
  output logic        ramreq,
  output logic        ramwe,
  input  logic [15:0] ramrdata,
  input  logic        ramack
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req_c;
  logic          hit_c;
  logic [15:0]   hit_data_c;
  logic          timeout_c;
  logic          unused_addr0;

  assign unused_addr0 = dmemaddr[0];
  assign req_c        = dmemread | dmemwrite;
  // Ack on the same edge as the timeout wins, so timeout requires no ack.
  assign timeout_c    = (state == S_REQ) & ~ramack & (cnt == TO_LAST);

`ifdef DMEM_LASTHIT_EN
  logic        lh_valid;
  logic [14:0] lh_addr;
  logic [15:0] lh_data;

  // Only a pure read can hit; read+write is a write and always goes to RAM.
  assign hit_c      = (state == S_IDLE) & dmemread & ~dmemwrite & lh_valid &
                      (lh_addr == dmemaddr[15:1]);
  assign hit_data_c = lh_data;

  // Last-access entry: refreshed on every completed transaction, dropped on timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      lh_valid <= 1'b0;
      lh_addr  <= '0;
      lh_data  <= '0;
    end else if (state == S_REQ) begin
      if (ramack) begin
        lh_valid <= 1'b1;
        lh_addr  <= ramaddr;
        lh_data  <= ramwe ? ramwdata : ramrdata;
      end else if (timeout_c) begin
        lh_valid <= 1'b0;
      end
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = 16'h0000;
`endif

  assign dmemstall = ~reset & (((state == S_IDLE) & req_c & ~hit_c) | (state == S_REQ));

  // Transaction FSM with registered RAM-side and core-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ramreq    <= 1'b0;
      ramwe     <= 1'b0;
      ramaddr   <= '0;
      ramwdata  <= '0;
      dmemrdata <= '0;
      dmemerr   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit_c) begin
            dmemrdata <= hit_data_c;
          end else if (req_c) begin
            ramaddr  <= dmemaddr[15:1];
            ramwdata <= dmemwdata;
            ramwe    <= dmemwrite;
            ramreq   <= 1'b1;
            cnt      <= '0;
            state    <= S_REQ;
            if (dmemread & dmemwrite) dmemerr <= 1'b1;
          end
        end
        S_REQ: begin
          if (ramack) begin
            ramreq <= 1'b0;
            if (!ramwe) dmemrdata <= ramrdata;
            state  <= S_DONE;
          end else if (timeout_c) begin
            ramreq  <= 1'b0;
            dmemerr <= 1'b1;
            if (!ramwe) dmemrdata <= 16'hDEAD;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // Core advances on this edge; the still-present request is ignored.
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: transaction-level model of RAM contents,
// sticky error, load data and the optional last-access entry, with randomized
// and directed transactions.
`timescale 1ns/1ps
module tb_dmem_bridge;

  localparam int unsigned TIMEOUT = 15;
`ifdef DMEM_LASTHIT_EN
  localparam bit LH_EN = 1'b1;
`else
  localparam bit LH_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dmemaddr = '0;
  logic [15:0] dmemwdata = '0;
  logic        dmemwrite = 1'b0;
  logic        dmemread = 1'b0;
  logic [15:0] dmemrdata;
  logic        dmemstall;
  logic        dmemerr;
  logic [14:0] ramaddr;
  logic [15:0] ramwdata;
  logic        ramreq;
  logic        ramwe;
  logic [15:0] ramrdata = '0;
  logic        ramack = 1'b0;

  always #5 clock = ~clock;

  dmem_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite), .dmemread(dmemread),
    .dmemrdata(dmemrdata), .dmemstall(dmemstall), .dmemerr(dmemerr),
    .ramaddr(ramaddr), .ramwdata(ramwdata), .ramreq(ramreq), .ramwe(ramwe),
    .ramrdata(ramrdata), .ramack(ramack)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] mem [0:32767];
  logic        m_err;
  logic [15:0] m_rdata;
  bit          m_lh_v;
  logic [14:0] m_lh_a;
  logic [15:0] m_lh_d;

  // Observations from the most recent transaction
  int          obs_stalls;
  bit          obs_anyreq;
  logic [14:0] obs_ramaddr;
  logic        obs_ramwe;
  logic [15:0] obs_ramwdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_err   = 1'b0;
    m_rdata = 16'h0000;
    m_lh_v  = 1'b0;
    m_lh_a  = '0;
    m_lh_d  = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; dmemread = 1'b0; dmemwrite = 1'b0; ramack = 1'b0;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One core transaction. k = REQ cycles before ack (1..TIMEOUT completes), 0 = never ack.
  task automatic txn(input logic [15:0] a, input logic [15:0] wd,
                     input logic rd, input logic wr, input int k);
    bit          hit;
    bit          ok;
    int          exp_stalls;
    logic [14:0] wa;
    wa  = a[15:1];
    hit = LH_EN && rd && !wr && m_lh_v && (m_lh_a == wa);
    @(negedge clock);
    dmemaddr = a; dmemwdata = wd; dmemread = rd; dmemwrite = wr;
    #1;
    obs_stalls = 0;
    obs_anyreq = 1'b0;
    if (hit) begin
      chk("hit_stall", 32'(dmemstall), 32'd0);
      @(posedge clock); #1;
      m_rdata = m_lh_d;
      chk("hit_rdata", 32'(dmemrdata), 32'(m_rdata));
      chk("hit_noreq", 32'(ramreq), 32'd0);
    end else begin
      ok = (k >= 1) && (k <= int'(TIMEOUT));
      exp_stalls = ok ? k + 1 : int'(TIMEOUT) + 1;
      while (dmemstall === 1'b1 && obs_stalls < int'(TIMEOUT) + 4) begin
        obs_stalls++;
        if (obs_stalls > 1) begin
          chk("req_held", 32'(ramreq), 32'd1);
          chk("ramaddr", 32'(ramaddr), 32'(wa));
          chk("ramwe", 32'(ramwe), 32'(wr));
          if (wr) chk("ramwdata", 32'(ramwdata), 32'(wd));
          obs_anyreq   = 1'b1;
          obs_ramaddr  = ramaddr;
          obs_ramwe    = ramwe;
          obs_ramwdata = ramwdata;
        end
        if (ok && obs_stalls == k + 1) begin
          ramack   = 1'b1;
          ramrdata = mem[wa];
        end
        @(posedge clock); #1;
        ramack   = 1'b0;
        ramrdata = 16'($urandom);
      end
      chk("stall_cycles", 32'(obs_stalls), 32'(exp_stalls));
      if (rd && wr) m_err = 1'b1;
      if (ok) begin
        if (wr) mem[wa] = wd;
        else    m_rdata = mem[wa];
        m_lh_v = 1'b1;
        m_lh_a = wa;
        m_lh_d = mem[wa];
      end else begin
        m_err = 1'b1;
        if (!wr) m_rdata = 16'hDEAD;
        m_lh_v = 1'b0;
      end
      chk("done_noreq", 32'(ramreq), 32'd0);
      chk("done_rdata", 32'(dmemrdata), 32'(m_rdata));
      chk("done_err", 32'(dmemerr), 32'(m_err));
      @(posedge clock); #1;
    end
    dmemread = 1'b0; dmemwrite = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[15'h0008] = 16'h1234;
    model_reset();

    // Reset values
    do_reset();
    #1;
    chk("rst_ramreq", 32'(ramreq), 32'd0);
    chk("rst_ramwe", 32'(ramwe), 32'd0);
    chk("rst_ramaddr", 32'(ramaddr), 32'd0);
    chk("rst_ramwdata", 32'(ramwdata), 32'd0);
    chk("rst_rdata", 32'(dmemrdata), 32'd0);
    chk("rst_err", 32'(dmemerr), 32'd0);
    chk("rst_stall", 32'(dmemstall), 32'd0);

    // Minimum-latency read
    txn(16'h0010, 16'h0000, 1'b1, 1'b0, 1);
    chk("lit_rd_stalls", 32'(obs_stalls), 32'd2);
    chk("lit_rd_ramaddr", 32'(obs_ramaddr), 32'h0008);
    chk("lit_rd_ramwe", 32'(obs_ramwe), 32'd0);
    chk("lit_rd_data", 32'(dmemrdata), 32'h1234);
    chk("lit_rd_err", 32'(dmemerr), 32'd0);

    // Write with ack delayed 5 cycles
    txn(16'h0020, 16'h00AB, 1'b0, 1'b1, 5);
    chk("lit_wr_stalls", 32'(obs_stalls), 32'd6);
    chk("lit_wr_ramwe", 32'(obs_ramwe), 32'd1);
    chk("lit_wr_ramwdata", 32'(obs_ramwdata), 32'h00AB);
    chk("lit_wr_ramaddr", 32'(obs_ramaddr), 32'h0010);
    chk("lit_wr_rdata_kept", 32'(dmemrdata), 32'h1234);

    // Ack on the timeout edge completes normally
    txn(16'h0022, 16'h0000, 1'b1, 1'b0, int'(TIMEOUT));
    chk("lit_ackwin_stalls", 32'(obs_stalls), 32'(TIMEOUT + 1));
    chk("lit_ackwin_err", 32'(dmemerr), 32'd0);

    // Randomized back-to-back traffic over a small address window
    for (int n = 0; n < 120; n++) begin
      logic [15:0] a;
      logic        w;
      int          k;
      a = 16'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) : $urandom_range(1, 6);
      txn(a, 16'($urandom), ~w, w, k);
    end

`ifdef DMEM_LASTHIT_EN
    // Last-access hits
    do_reset();
    mem[15'h0008] = 16'h1234;
    txn(16'h0010, 16'h0000, 1'b1, 1'b0, 1);
    chk("lh_miss_req", 32'(obs_anyreq), 32'd1);
    txn(16'h0011, 16'h0000, 1'b1, 1'b0, 1);
    chk("lh_hit_stalls", 32'(obs_stalls), 32'd0);
    chk("lh_hit_noreq", 32'(obs_anyreq), 32'd0);
    chk("lh_hit_data", 32'(dmemrdata), 32'h1234);
    txn(16'h0010, 16'hBEEF, 1'b0, 1'b1, 2);
    chk("lh_wr_req", 32'(obs_anyreq), 32'd1);
    txn(16'h0010, 16'h0000, 1'b1, 1'b0, 1);
    chk("lh_rehit_noreq", 32'(obs_anyreq), 32'd0);
    chk("lh_rehit_data", 32'(dmemrdata), 32'hBEEF);
`endif

    // Simultaneous read+write is a write with error
    do_reset();
    txn(16'h0030, 16'h5A5A, 1'b1, 1'b1, 2);
    chk("rw_ramwe", 32'(obs_ramwe), 32'd1);
    chk("rw_ramwdata", 32'(obs_ramwdata), 32'h5A5A);
    chk("rw_err", 32'(dmemerr), 32'd1);

    // Reset during REQ; late ack ignored
    do_reset();
    @(negedge clock);
    dmemaddr = 16'h0040; dmemread = 1'b1;
    @(posedge clock); #1;
    chk("mid_in_req", 32'(ramreq), 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1; dmemread = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_ramreq", 32'(ramreq), 32'd0);
    chk("mid_rst_stall", 32'(dmemstall), 32'd0);
    reset = 1'b0; ramack = 1'b1; ramrdata = 16'h7777;
    @(posedge clock); #1;
    ramack = 1'b0;
    chk("mid_late_ramreq", 32'(ramreq), 32'd0);
    chk("mid_late_stall", 32'(dmemstall), 32'd0);
    chk("mid_late_rdata", 32'(dmemrdata), 32'd0);
    chk("mid_late_err", 32'(dmemerr), 32'd0);
    model_reset();

    // Timeout, then sticky error across a normal read
    txn(16'h0050, 16'h0000, 1'b1, 1'b0, 0);
    chk("to_stalls", 32'(obs_stalls), 32'(TIMEOUT + 1));
    chk("to_rdata", 32'(dmemrdata), 32'hDEAD);
    chk("to_err", 32'(dmemerr), 32'd1);
    txn(16'h0052, 16'h0000, 1'b1, 1'b0, 2);
    chk("to_err_sticky", 32'(dmemerr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge directly downstream of the pipeline's MEM stage. It takes the core's single-cycle data-memory request (`dmemaddr`, `dmemwdata`, `dmemwrite`, `dmemread`) and converts it into a req/ack transaction on an external word-addressed RAM port. It stalls the core with `dmemstall` until the transaction completes, then presents read data on `dmemrdata`, where the MEM/WB register captures it. A timeout counter bounds every transaction, and an optional one-entry last-access register returns repeat reads with no stall.

## Interface
- `TIMEOUT`, default 15: cycles spent in REQ without `ramack` before the transaction is abandoned. Legal range 1..255.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `dmemaddr` in 16: byte address from EX/MEM; bit 0 ignored.
- `dmemwdata` in 16: store data.
- `dmemwrite` in 1: store request.
- `dmemread` in 1: load request.
- `dmemrdata` out 16: load data, registered.
- `dmemstall` out 1: freeze request to the core, combinational.
- `dmemerr` out 1: sticky error flag (timeout or simultaneous read+write).
- `ramaddr` out 15: word address, registered; `dmemaddr[15:1]` of the latched request.
- `ramwdata` out 16: registered store data.
- `ramreq` out 1: registered request, held until ack or timeout.
- `ramwe` out 1: registered; 1 for a write transaction, 0 for a read.
- `ramrdata` in 16: RAM read data, valid in the cycle `ramack`=1.
- `ramack` in 1: RAM completion, sampled at the rising edge; ignored while `ramreq`=0.

## Operation
- States:
  - IDLE: no transaction in progress.
  - REQ: transaction outstanding on the RAM port.
  - DONE: one cycle in which the core is released.
- IDLE, with `dmemread` or `dmemwrite` high and no last-hit:
  - `dmemstall`=1 in the same cycle.
  - At the edge: latch address/data/we into `ramaddr`/`ramwdata`/`ramwe`, set `ramreq`=1, clear the timeout counter, go to REQ.
- `dmemread` and `dmemwrite` both high: treated as a write; `dmemerr` is set.
- REQ:
  - `dmemstall`=1 throughout; the counter increments each cycle.
  - `ramack`=1 at an edge: drop `ramreq`. On a read, load `dmemrdata` <= `ramrdata`. Go to DONE.
  - Counter equals TIMEOUT-1 with no ack: drop `ramreq`, set `dmemerr`, load `dmemrdata` <= 16'hDEAD (reads only), go to DONE.
- DONE:
  - `dmemstall`=0; the core advances at this edge.
  - The bridge returns to IDLE unconditionally and ignores the still-present request in this cycle.
- Writes leave `dmemrdata` unchanged.
- `dmemstall` = (IDLE & (rd|wr) & ~hit) | REQ. It is forced to 0 while `reset`=1.

## Timing
- Reset values:
  - state IDLE.
  - `ramreq`=0, `ramwe`=0, `ramaddr`=0, `ramwdata`=0.
  - `dmemrdata`=0, `dmemerr`=0, counter=0, last-access valid=0.
- Minimum miss latency: request seen in cycle N, ack in N+1, data valid and stall low in N+2. Stall lasts 2 cycles.
- Ack after k cycles in REQ gives k+1 stall cycles.
- A timeout transaction stalls for TIMEOUT+1 cycles.
- `ramack` arriving in the same edge as the timeout wins: the transaction is a normal completion and no error is flagged.
- Reset mid-transaction: the next edge returns to IDLE with `ramreq`=0. No completion is reported, and a late `ramack` is ignored.
- Back-to-back requests: a new request is accepted in the IDLE cycle that follows DONE. There is no gap beyond DONE.

## Configuration
- `DMEM_LASTHIT_EN` defined:
  - One-entry register {valid, word address, data}, updated on every completed (non-timeout) read or write.
  - In IDLE, a read whose `dmemaddr[15:1]` matches a valid entry is a hit. The hit is served with zero stall: `dmemrdata` <= stored data at the edge, state stays IDLE, no RAM transaction.
  - A write never hits; it always goes to RAM and then refreshes the entry.
  - A timeout invalidates the entry.
- `DMEM_LASTHIT_EN` undefined: no register; every read goes to RAM.

## Test plan
- Reset, then read at 0x0010 with `ramack` one cycle after `ramreq`, `ramrdata`=0x1234:
  - `ramaddr`=0x0008, `ramwe`=0.
  - Stall high for 2 cycles, `dmemrdata`=0x1234 in DONE, `dmemerr`=0.
- Write 0x00AB to 0x0020 with ack delayed 5 cycles:
  - `ramwe`=1, `ramwdata`=0x00AB, `ramaddr`=0x0010.
  - Stall high for 6 cycles, `dmemrdata` unchanged.
- Read with no ack at TIMEOUT=15:
  - `ramreq` drops after 15 cycles in REQ, `dmemrdata`=0xDEAD, `dmemerr`=1 and stays 1.
- Assert `reset` during REQ:
  - Next cycle `ramreq`=0, state IDLE, `dmemstall`=0.
  - An ack pulse one cycle later has no effect.
- `dmemread`=`dmemwrite`=1: write transaction issued, `dmemerr`=1.
- With `DMEM_LASTHIT_EN`: read 0x0010 (miss, returns 0x1234), then read 0x0011:
  - Second read is a zero-stall hit, no `ramreq`, `dmemrdata`=0x1234.
  - A following write to 0x0010 followed by a read of 0x0010 returns the new data without `ramreq`.
